// File: rtl/loong_pkg.sv
// loong_pkg: shared LOONG types, S-boxes, round constants and inverse mixing masks.
package loong_pkg;
    localparam int ROUNDS = 16;
    localparam int NIBW = 4;
    typedef logic [NIBW-1:0] nibble_t;
    typedef nibble_t [0:3][0:3] state_t;
    typedef enum logic [2:0] {IDLE, ARK, ISUB1, IMCOL, IMROW, ISUB2, FARK, OUT} loong_st_e;
    typedef enum logic [1:0] {OP_ISUB, OP_IMCOL, OP_IMROW, OP_PASS} loong_op_e;
    localparam logic [0:15][3:0] LOONG_SBOX = 64'hC56B90AD3EF84712;
    localparam logic [0:15][3:0] LOONG_INV_SBOX = 64'h5EF8C12DB463079A;
    // Bit k of entry j selects input k into output j; MixCol is an involution, MixRow a prefix XOR.
    localparam logic [0:3][3:0] INV_MIXCOL = {4'b1110, 4'b1101, 4'b1011, 4'b0111};
    localparam logic [0:3][3:0] INV_MIXROW = {4'b0001, 4'b0011, 4'b0111, 4'b1111};

    function automatic state_t loong_rc(input logic [4:0] idx);
        state_t rc;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                rc[r][c] = {r[1:0], c[1:0]} ^ idx[3:0] ^ (idx[4] ? 4'hA : 4'h0);
        return rc;
    endfunction
endpackage

// File: rtl/loong_inv_layer.sv
// loong_inv_layer: combinational InvSub / InvMixCol / InvMixRow selected by op.
module loong_inv_layer
    import loong_pkg::*;
(
    input  loong_op_e op,
    input  state_t    din,
    output state_t    dout
);
    state_t isub, imcol, imrow;

    always_comb begin
        isub = din;
        imcol = '0;
        imrow = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                isub[r][c] = LOONG_INV_SBOX[din[r][c]];
                for (int k = 0; k < 4; k++) begin
                    if (INV_MIXCOL[r][k]) imcol[r][c] = imcol[r][c] ^ din[k][c];
                    if (INV_MIXROW[c][k]) imrow[r][c] = imrow[r][c] ^ din[r][k];
                end
            end
    end

    assign dout = op == OP_ISUB ? isub : op == OP_IMCOL ? imcol : op == OP_IMROW ? imrow : din;
endmodule

// File: rtl/loong_dec.sv
// loong_dec: iterative LOONG decryptor, one inverse layer per cycle.
module loong_dec
    import loong_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           do_loong,
    input  nibble_t [0:15] ciphertext,
    input  nibble_t [0:15] roundKey,
    output nibble_t [0:15] plaintext,
    output logic           busy,
    output logic           done
);
    loong_st_e state, state_nx;
    loong_op_e op;
    state_t s, k, s_nx, layer_out;
    logic [4:0] rnd;

    loong_inv_layer u_layer (.op(op), .din(s), .dout(layer_out));

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = do_loong ? ARK : IDLE;
            ARK:     state_nx = ISUB1;
            ISUB1:   state_nx = IMCOL;
            IMCOL:   state_nx = IMROW;
            IMROW:   state_nx = ISUB2;
            ISUB2:   state_nx = rnd == 5'd1 ? FARK : ARK;
            FARK:    state_nx = OUT;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        op = state == IMCOL ? OP_IMCOL : state == IMROW ? OP_IMROW :
             (state == ISUB1 || state == ISUB2) ? OP_ISUB : OP_PASS;
        s_nx = state == ARK ? s ^ k ^ loong_rc(rnd) :
               state == FARK ? s ^ k ^ loong_rc(5'd0) : layer_out;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            s <= '0;
            k <= '0;
            rnd <= '0;
            plaintext <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= state == OUT;
            if (state == IDLE && do_loong) begin
                s <= state_t'(ciphertext);
                k <= state_t'(roundKey);
                rnd <= 5'(ROUNDS);
                busy <= 1'b1;
            end else if (state == OUT) begin
                plaintext <= s;
                busy <= 1'b0;
            end else if (state != IDLE)
                s <= s_nx;
            if (state == ISUB2) rnd <= rnd - 5'd1;
        end
endmodule
